// File: rtl/clk_div_prog_pkg.sv
// rtl/clk_div_prog_pkg.sv - shared defaults for the programmable clock divider
package clk_div_pkg;

    localparam int DEFAULT_WIDTH     = 17;
    localparam int DEFAULT_RESET_DIV = 2 ** 16;

endpackage

// File: rtl/clk_div_prog_if.sv
// rtl/clk_div_prog_if.sv - control and output bundle of the programmable clock divider
import clk_div_pkg::*;

interface clk_div_prog_if #(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             enable;
    logic [WIDTH-1:0] div_value;
    logic             div_load;
    logic             div_clock;
    logic             tick;
    logic             load_pending;

    modport master (
        output enable, div_value, div_load,
        input  div_clock, tick, load_pending
    );

    modport slave (
        input  enable, div_value, div_load,
        output div_clock, tick, load_pending
    );
endinterface

// File: rtl/clk_div_prog.sv
// rtl/clk_div_prog.sv - programmable divider producing a 2*D square wave and a tick every D cycles
import clk_div_pkg::*;

module clk_div_prog #(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int RESET_DIV = DEFAULT_RESET_DIV
) (
    input logic           clock,
    input logic           reset,
    clk_div_prog_if.slave bus
);

    localparam logic [WIDTH-1:0] RST_DIV = WIDTH'(RESET_DIV);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] div_q;
    logic [WIDTH-1:0] pend_q;
    logic             div_clock_q;
    logic             tick_q;
    logic             pending_q;
    logic [WIDTH-1:0] load_div;
    logic             terminal;

    // A zero divisor is meaningless; it is folded to 1 as soon as it is seen.
    function automatic logic [WIDTH-1:0] eff_div(input logic [WIDTH-1:0] v);
        return (v == '0) ? WIDTH'(1) : v;
    endfunction

    always_comb begin
        load_div = eff_div(bus.div_value);
        terminal = bus.enable && (cnt == WIDTH'(div_q - WIDTH'(1)));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt         <= '0;
            div_q       <= RST_DIV;
            pend_q      <= RST_DIV;
            div_clock_q <= 1'b0;
            tick_q      <= 1'b0;
            pending_q   <= 1'b0;
        end else if (!bus.enable) begin
            // Idle cycles are a safe point to switch divisors immediately.
            tick_q <= 1'b0;
            if (bus.div_load) begin
                div_q     <= load_div;
                cnt       <= '0;
                pending_q <= 1'b0;
            end else if (pending_q) begin
                div_q     <= pend_q;
                cnt       <= '0;
                pending_q <= 1'b0;
            end
        end else if (terminal) begin
            cnt         <= '0;
            tick_q      <= 1'b1;
            div_clock_q <= ~div_clock_q;
            if (bus.div_load) begin
                div_q     <= load_div;
                pending_q <= 1'b0;
            end else if (pending_q) begin
                div_q     <= pend_q;
                pending_q <= 1'b0;
            end
        end else begin
            // Mid-period loads wait for the terminal edge so no period is truncated.
            cnt    <= cnt + WIDTH'(1);
            tick_q <= 1'b0;
            if (bus.div_load) begin
                pend_q    <= load_div;
                pending_q <= 1'b1;
            end
        end
    end

    assign bus.div_clock    = div_clock_q;
    assign bus.tick         = tick_q;
    assign bus.load_pending = pending_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// tb/tb_clk_div_prog.sv - randomized and directed checks of clk_div_prog against a behavioural model
module tb_clk_div_prog;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    clk_div_prog_if #(.WIDTH(8)) bus8 ();
    clk_div_prog_if #(.WIDTH(4)) bus4 ();

    clk_div_prog #(.WIDTH(8), .RESET_DIV(200)) u8 (.clock(clk), .reset(rst), .bus(bus8));
    clk_div_prog #(.WIDTH(4), .RESET_DIV(15))  u4 (.clock(clk), .reset(rst), .bus(bus4));

    int errors = 0;
    int checks = 0;

    int m_div, m_cnt, m_pend, m_pending, m_clk, m_tick;
    int ticks_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int eff(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    task automatic model_reset();
        m_div = 200; m_cnt = 0; m_pend = 200; m_pending = 0; m_clk = 0; m_tick = 0;
    endtask

    // Model of one clock edge, written directly from the divider's rules.
    task automatic model_step(input int en, input int ld, input int val);
        m_tick = 0;
        if (en == 0) begin
            if (ld != 0) begin m_div = eff(val); m_cnt = 0; m_pending = 0; end
            else if (m_pending != 0) begin m_div = m_pend; m_cnt = 0; m_pending = 0; end
        end else if (m_cnt == m_div - 1) begin
            m_tick = 1; m_cnt = 0; m_clk = 1 - m_clk;
            if (ld != 0) begin m_div = eff(val); m_pending = 0; end
            else if (m_pending != 0) begin m_div = m_pend; m_pending = 0; end
        end else begin
            m_cnt = m_cnt + 1;
            if (ld != 0) begin m_pend = eff(val); m_pending = 1; end
        end
    endtask

    task automatic cyc(input int en, input int ld, input int val, input string tag);
        bus8.enable    = (en != 0);
        bus8.div_load  = (ld != 0);
        bus8.div_value = 8'(val);
        model_step(en, ld, val);
        @(posedge clk);
        #1;
        bus8.div_load = 1'b0;
        if (m_tick != 0) ticks_seen++;
        chk({tag, ".tick"}, 32'(bus8.tick), 32'(m_tick));
        chk({tag, ".div_clock"}, 32'(bus8.div_clock), 32'(m_clk));
        chk({tag, ".load_pending"}, 32'(bus8.load_pending), 32'(m_pending));
        chk({tag, ".cnt"}, 32'(u8.cnt), 32'(m_cnt));
    endtask

    initial begin
        bus8.enable = 1'b0; bus8.div_load = 1'b0; bus8.div_value = '0;
        bus4.enable = 1'b0; bus4.div_load = 1'b0; bus4.div_value = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("reset.tick", 32'(bus8.tick), 32'd0);
        chk("reset.div_clock", 32'(bus8.div_clock), 32'd0);
        chk("reset.load_pending", 32'(bus8.load_pending), 32'd0);
        chk("reset.cnt", 32'(u8.cnt), 32'd0);
        chk("reset.div_q", 32'(u8.div_q), 32'd200);

        // Divide by 5: ticks on enabled edges 5, 10, 15.
        cyc(0, 1, 5, "d5_load");
        ticks_seen = 0;
        for (int i = 1; i <= 15; i++) begin
            cyc(1, 0, 0, "d5_run");
            chk("d5_tick_edge", 32'(bus8.tick), (i % 5 == 0) ? 32'd1 : 32'd0);
        end
        chk("d5_tick_count", 32'(ticks_seen), 32'd3);

        // Load 3 mid-period at cnt=1; it lands at the next terminal edge.
        cyc(1, 0, 0, "d5to3_pre");
        cyc(1, 1, 3, "d5to3_load");
        chk("d5to3_pending", 32'(bus8.load_pending), 32'd1);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, "d5to3_wait");
        chk("d5to3_applied", 32'(u8.div_q), 32'd3);
        ticks_seen = 0;
        for (int i = 0; i < 9; i++) cyc(1, 0, 0, "d3_run");
        chk("d3_tick_count", 32'(ticks_seen), 32'd3);

        // Zero divisor behaves as divide-by-one.
        cyc(0, 1, 0, "d0_load");
        for (int i = 0; i < 6; i++) begin
            cyc(1, 0, 0, "d0_run");
            chk("d0_tick_const", 32'(bus8.tick), 32'd1);
        end

        // Divide by 4, pause at cnt=2 for seven cycles, then resume.
        cyc(0, 1, 4, "d4_load");
        cyc(1, 0, 0, "d4_run");
        cyc(1, 0, 0, "d4_run");
        for (int i = 0; i < 7; i++) begin
            cyc(0, 0, 0, "d4_hold");
            chk("d4_hold_cnt", 32'(u8.cnt), 32'd2);
        end
        cyc(1, 0, 0, "d4_resume1");
        cyc(1, 0, 0, "d4_resume2");
        chk("d4_resume_tick", 32'(bus8.tick), 32'd1);

        // Pending load applied as soon as enable drops.
        cyc(1, 1, 7, "fall_load");
        cyc(0, 0, 0, "fall_apply");
        chk("fall_div_q", 32'(u8.div_q), 32'd7);

        // Divide by 6 with a pending 9, then an asynchronous reset between edges.
        cyc(0, 1, 6, "d6_load");
        for (int i = 0; i < 7; i++) cyc(1, 0, 0, "d6_run");
        cyc(1, 1, 9, "d6_pend");
        chk("d6_pend_set", 32'(bus8.load_pending), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("areset.tick", 32'(bus8.tick), 32'd0);
        chk("areset.div_clock", 32'(bus8.div_clock), 32'd0);
        chk("areset.load_pending", 32'(bus8.load_pending), 32'd0);
        chk("areset.div_q", 32'(u8.div_q), 32'd200);
        chk("areset.cnt", 32'(u8.cnt), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Random traffic against the model.
        cyc(0, 1, 3, "rnd_init");
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 9) < 8) ? 1 : 0,
                ($urandom_range(0, 9) == 0) ? 1 : 0,
                int'($urandom_range(0, 12)), "rnd");
        end

        // WIDTH=4 at the largest divisor: tick every 15, counter tops out at 14.
        bus4.div_value = 4'd15;
        bus4.div_load  = 1'b1;
        @(posedge clk);
        #1;
        bus4.div_load = 1'b0;
        bus4.enable   = 1'b1;
        for (int k = 1; k <= 45; k++) begin
            @(posedge clk);
            #1;
            chk("w4_tick", 32'(bus4.tick), (k % 15 == 0) ? 32'd1 : 32'd0);
            chk("w4_cnt", 32'(u4.cnt), 32'(k % 15));
            chk("w4_cnt_max", 32'(u4.cnt <= 4'd14), 32'd1);
        end
        bus4.enable = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/clk_div_prog.md
CLK_DIV_PROG -- requirements
Module: clk_div_prog

Interface
REQ-001 SHALL provide parameter WIDTH, default 17: width of divisor and counter.
REQ-002 SHALL provide parameter RESET_DIV, default 2**16: divisor loaded at reset. Must be nonzero and < 2**WIDTH.
REQ-003 SHALL provide port clock, input, 1: sole clock, rising-edge.
REQ-004 SHALL provide port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL provide port enable, input, 1: count enable.
REQ-006 SHALL provide port div_value, input, WIDTH: requested divisor D.
REQ-007 SHALL provide port div_load, input, 1: single-cycle request to capture div_value.
REQ-008 SHALL provide port div_clock, output, 1: square wave, period 2*D cycles, registered.
REQ-009 SHALL provide port tick, output, 1: one-cycle pulse every D enabled cycles, registered.
REQ-010 SHALL provide port load_pending, output, 1: captured divisor not yet applied.

Function
REQ-011 SHALL hold the active divisor div_q and the counter cnt, both WIDTH bits.
REQ-012 SHALL treat a divisor value of 0 as 1, both when captured and when applied.
REQ-013 SHALL increment cnt by 1 on each clock edge with enable=1 and cnt != div_q-1.
REQ-014 SHALL treat a cycle with enable=1 and cnt == div_q-1 as the terminal cycle. On that edge: cnt<=0, tick<=1, div_clock<=~div_clock.
REQ-015 SHALL drive tick=0 on every edge that is not a terminal edge.
REQ-016 SHALL make cnt, div_clock and div_q hold, with tick=0, while enable=0.
REQ-017 SHALL, when div_load=1 in a non-terminal enabled cycle, capture div_value into pend_q and set load_pending=1 on that edge.
REQ-018 SHALL, at the next terminal edge after a capture, set div_q<=pend_q and clear load_pending. cnt restarts at 0 under the new divisor.
REQ-019 SHALL, when div_load=1 in a terminal cycle, apply div_value directly to div_q on that edge, with load_pending=0.
REQ-020 SHALL, when div_load=1 while enable=0, apply div_value to div_q and clear cnt to 0 on that edge, with load_pending=0.
REQ-021 SHALL, on a second div_load while load_pending=1, overwrite pend_q. Only the latest value is applied.
REQ-022 SHALL, when a pending load exists and enable then falls, apply pend_q on the first enable=0 edge and clear cnt and load_pending.
REQ-023 SHALL, with D=1, give tick=1 on every enabled cycle and div_clock toggling every enabled cycle.
REQ-024 SHALL, with D=2**WIDTH-1, count 0..2**WIDTH-2 with no wrap past the terminal value.
REQ-025 SHALL give tick its first pulse D enabled edges after enable first rises out of reset.
REQ-026 SHALL generate all outputs from flops, with no combinational path from any input to any output.

Reset
REQ-027 SHALL, on reset=1 and regardless of clock, set cnt=0, div_q=RESET_DIV, pend_q=RESET_DIV, div_clock=0, tick=0, load_pending=0.
REQ-028 SHALL discard any pending load when reset is asserted mid-operation.
REQ-029 SHALL start counting on the first clock edge after reset deasserts with enable=1.

Structure
REQ-030 SHALL place the default WIDTH and RESET_DIV constants in shared package clk_div_pkg.
REQ-031 SHALL be a single module with no sub-module. Counter, divisor registers and output flops are inline.
REQ-032 SHALL be implementable in 120-400 lines of RTL.

Verification
REQ-033 SHALL cover: WIDTH=8, div_value=5 loaded while disabled, enable=1 -> tick high on edges 5, 10, 15; div_clock toggles at the same edges (period 10).
REQ-034 SHALL cover: D=5 running, div_load with 3 at cnt=1 -> load_pending=1 until the next terminal edge; subsequent ticks every 3 cycles.
REQ-035 SHALL cover: div_value=0 loaded -> behaves as D=1; tick constant 1 while enabled; div_clock period 2.
REQ-036 SHALL cover: D=4, enable dropped at cnt=2 for 7 cycles -> cnt holds at 2 and tick=0; tick occurs 2 edges after re-enable.
REQ-037 SHALL cover: D=6 with a pending load of 9, reset pulsed asynchronously between edges -> outputs immediately 0, div_q=RESET_DIV, load_pending=0.
REQ-038 SHALL cover: WIDTH=4, D=15 -> tick every 15 cycles; cnt never exceeds 14.
